// File: rtl/funnel_host_proxy.sv
// Host-side proxy for the funnel pipe links.
// Outbound: say(v) calls are wrapped into 144-bit request messages and queued.
// Inbound: indication messages are validated, unwrapped into heard(v) calls and
// queued; malformed messages are consumed, dropped and counted (saturating).

// Small synchronous FIFO used once per direction. The head entry is driven
// straight from storage, so a push is first visible on the cycle after it is
// accepted (no write-to-read bypass).
module funnel_host_proxy_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH (power of 2).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state; reset empties the FIFO (storage contents are left as-is).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage write; never written while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && push_i) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

module funnel_host_proxy #(
    parameter int           DEPTH    = 2,
    parameter logic [7:0]   SAY_ID   = 8'h00,
    parameter logic [7:0]   HEARD_ID = 8'h00,
    parameter int           ERR_W    = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    // host say() method
    input  logic             say__ENA,
    input  logic [31:0]      say_v,
    output logic             say__RDY,
    // request pipe toward the DUT
    output logic             request_enq__ENA,
    output logic [143:0]     request_enq_v,
    input  logic             request_enq__RDY,
    // indication pipe from the DUT
    input  logic             indication_enq__ENA,
    input  logic [143:0]     indication_enq_v,
    output logic             indication_enq__RDY,
    // host heard() method
    output logic             heard__ENA,
    output logic [31:0]      heard_v,
    input  logic             heard__RDY,
    output logic [ERR_W-1:0] errCount
);
    localparam logic [7:0] ONE_WORD = 8'd1;

    // ---------------- outbound: say -> request ----------------
    logic         out_full, out_empty, out_push, out_pop;
    logic [143:0] out_msg, out_head;

    // Message format: {id, length, 96'b0, argument}.
    assign out_msg  = {SAY_ID, ONE_WORD, 96'b0, say_v};

    // Ready comes from registered occupancy only; gated low while in reset.
    assign say__RDY         = nRST & ~out_full;
    assign out_push         = say__ENA & say__RDY;
    assign request_enq__ENA = nRST & ~out_empty & request_enq__RDY;
    assign out_pop          = request_enq__ENA;
    assign request_enq_v    = nRST ? out_head : '0;

    funnel_host_proxy_fifo #(.DEPTH(DEPTH), .W(144)) u_out_fifo (
        .clk     (CLK),
        .rst_n   (nRST),
        .push_i  (out_push),
        .data_i  (out_msg),
        .pop_i   (out_pop),
        .full_o  (out_full),
        .empty_o (out_empty),
        .head_o  (out_head)
    );

    // ---------------- inbound: indication -> heard ----------------
    logic        in_full, in_empty, in_xfer, in_ok, in_push, in_bad, in_pop;
    logic [31:0] in_head;
    logic        unused_in_bits;

    assign indication_enq__RDY = nRST & ~in_full;
    assign in_xfer = indication_enq__ENA & indication_enq__RDY;
    // Only id and length are checked; the zero padding is not policed.
    assign in_ok   = (indication_enq_v[143:136] == HEARD_ID) &&
                     (indication_enq_v[135:128] == ONE_WORD);
    assign in_push = in_xfer & in_ok;
    assign in_bad  = in_xfer & ~in_ok;
    assign unused_in_bits = ^indication_enq_v[127:32];

    assign heard__ENA = nRST & ~in_empty & heard__RDY;
    assign in_pop     = heard__ENA;
    assign heard_v    = nRST ? in_head : '0;

    funnel_host_proxy_fifo #(.DEPTH(DEPTH), .W(32)) u_in_fifo (
        .clk     (CLK),
        .rst_n   (nRST),
        .push_i  (in_push),
        .data_i  (indication_enq_v[31:0]),
        .pop_i   (in_pop),
        .full_o  (in_full),
        .empty_o (in_empty),
        .head_o  (in_head)
    );

    // ---------------- drop counter ----------------
    logic [ERR_W-1:0] err_q, err_d;

    // Saturating increment on each dropped inbound message.
    always_comb begin
        err_d = err_q;
        if (in_bad && (err_q != '1)) err_d = err_q + ERR_W'(1);
    end

    // Drop counter register.
    always_ff @(posedge CLK) begin
        if (!nRST) err_q <= '0;
        else       err_q <= err_d;
    end

    assign errCount = err_q;
endmodule

// File: tb/tb_funnel_host_proxy.sv
module tb_funnel_host_proxy;
    localparam int ERR_W = 2;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         say_ena;
    logic [31:0]  say_v;
    logic         say_rdy;
    logic         req_ena;
    logic [143:0] req_v;
    logic         req_rdy;
    logic         ind_ena;
    logic [143:0] ind_v;
    logic         ind_rdy;
    logic         heard_ena;
    logic [31:0]  heard_v;
    logic         heard_rdy;
    logic [ERR_W-1:0] err_cnt;

    int checks = 0;
    int errors = 0;

    logic [143:0] exp_req[$];
    logic [31:0]  exp_heard[$];
    logic [143:0] e_req;
    logic [31:0]  e_heard;

    always #5 CLK = ~CLK;

    funnel_host_proxy #(.DEPTH(2), .SAY_ID(8'h00), .HEARD_ID(8'h00), .ERR_W(ERR_W)) dut (
        .CLK                 (CLK),
        .nRST                (nRST),
        .say__ENA            (say_ena),
        .say_v               (say_v),
        .say__RDY            (say_rdy),
        .request_enq__ENA    (req_ena),
        .request_enq_v       (req_v),
        .request_enq__RDY    (req_rdy),
        .indication_enq__ENA (ind_ena),
        .indication_enq_v    (ind_v),
        .indication_enq__RDY (ind_rdy),
        .heard__ENA          (heard_ena),
        .heard_v             (heard_v),
        .heard__RDY          (heard_rdy),
        .errCount            (err_cnt)
    );

    // Monitor: every pipe/method transfer out of the DUT is checked against the scoreboard.
    always @(negedge CLK) begin
        if (req_ena === 1'b1) begin
            checks++;
            if (exp_req.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected: got %h, nothing expected", req_v);
            end else begin
                e_req = exp_req.pop_front();
                if (req_v !== e_req) begin
                    errors++;
                    $display("FAIL req_data: got %h expected %h", req_v, e_req);
                end
            end
        end
        if (heard_ena === 1'b1) begin
            checks++;
            if (exp_heard.size() == 0) begin
                errors++;
                $display("FAIL heard_unexpected: got %h, nothing expected", heard_v);
            end else begin
                e_heard = exp_heard.pop_front();
                if (heard_v !== e_heard) begin
                    errors++;
                    $display("FAIL heard_data: got %h expected %h", heard_v, e_heard);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [143:0] mk(input logic [7:0] id, input logic [7:0] len, input logic [31:0] arg);
        return {id, len, 96'b0, arg};
    endfunction

    task automatic do_say(input logic [31:0] v);
        int n = 0;
        while (say_rdy !== 1'b1 && n < 50) begin tick(); n++; end
        checks++;
        if (n == 50) begin
            errors++;
            $display("FAIL say_timeout: say__RDY=%b expected 1", say_rdy);
        end else begin
            say_ena = 1'b1;
            say_v   = v;
            exp_req.push_back(mk(8'h00, 8'd1, v));
            tick();
            say_ena = 1'b0;
            say_v   = '0;
        end
    endtask

    task automatic do_ind(input logic [143:0] msg, input bit good);
        int n = 0;
        while (ind_rdy !== 1'b1 && n < 50) begin tick(); n++; end
        checks++;
        if (n == 50) begin
            errors++;
            $display("FAIL ind_timeout: indication__RDY=%b expected 1", ind_rdy);
        end else begin
            ind_ena = 1'b1;
            ind_v   = msg;
            if (good) exp_heard.push_back(msg[31:0]);
            tick();
            ind_ena = 1'b0;
            ind_v   = '0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0; say_ena = 1'b0; say_v = '0; req_rdy = 1'b1;
        ind_ena = 1'b0; ind_v = '0; heard_rdy = 1'b1;
        tick(); tick();
        @(negedge CLK);
        chk("rst_say_rdy",   144'(say_rdy),   144'(0));
        chk("rst_req_ena",   144'(req_ena),   144'(0));
        chk("rst_ind_rdy",   144'(ind_rdy),   144'(0));
        chk("rst_heard_ena", 144'(heard_ena), 144'(0));
        chk("rst_req_v",     req_v,           144'(0));
        chk("rst_heard_v",   144'(heard_v),   144'(0));
        chk("rst_err",       144'(err_cnt),   144'(0));
        nRST = 1'b1;
        tick();
        chk("rel_say_rdy", 144'(say_rdy), 144'(1));

        // 1: single say, visible the cycle after acceptance
        do_say(32'hDEADBEEF);
        @(negedge CLK);
        chk("lat_req_ena", 144'(req_ena), 144'(1));
        chk("lat_say_rdy", 144'(say_rdy), 144'(1));
        tick(); tick();

        // 2: backpressure, FIFO fills at 2, order preserved after release
        req_rdy = 1'b0;
        do_say(32'd1);
        do_say(32'd2);
        @(negedge CLK);
        chk("full_say_rdy", 144'(say_rdy), 144'(0));
        chk("full_req_ena", 144'(req_ena), 144'(0));
        tick();
        req_rdy = 1'b1;
        do_say(32'd3);
        repeat (4) tick();

        // 3: valid inbound message, one-cycle latency
        do_ind(mk(8'h00, 8'd1, 32'h12345678), 1'b1);
        @(negedge CLK);
        chk("in_lat_heard_ena", 144'(heard_ena), 144'(1));
        tick();
        chk("in_err0", 144'(err_cnt), 144'(0));

        // 4: bad id, bad length, then a good one
        do_ind(mk(8'h05, 8'd1, 32'hAAAA0001), 1'b0);
        do_ind(mk(8'h00, 8'd2, 32'hAAAA0002), 1'b0);
        chk("drop_ind_rdy", 144'(ind_rdy), 144'(1));
        do_ind(mk(8'h00, 8'd1, 32'hCAFEF00D), 1'b1);
        repeat (3) tick();
        chk("drop_err2", 144'(err_cnt), 144'(2));

        // 5: saturation of a 2-bit counter
        do_ind(mk(8'h07, 8'd1, 32'h1), 1'b0);
        tick();
        chk("sat_err3", 144'(err_cnt), 144'(3));
        do_ind(mk(8'h07, 8'd3, 32'h2), 1'b0);
        do_ind(mk(8'h01, 8'd0, 32'h3), 1'b0);
        tick();
        chk("sat_hold", 144'(err_cnt), 144'(3));

        // 6: reset with both FIFOs full
        req_rdy = 1'b0; heard_rdy = 1'b0;
        do_say(32'h0000A001);
        do_say(32'h0000A002);
        do_ind(mk(8'h00, 8'd1, 32'h0000B001), 1'b1);
        do_ind(mk(8'h00, 8'd1, 32'h0000B002), 1'b1);
        @(negedge CLK);
        chk("pre_rst_say_rdy", 144'(say_rdy), 144'(0));
        chk("pre_rst_ind_rdy", 144'(ind_rdy), 144'(0));
        tick();
        nRST = 1'b0;
        req_rdy = 1'b1; heard_rdy = 1'b1;
        exp_req.delete();
        exp_heard.delete();
        tick();
        @(negedge CLK);
        chk("mid_rst_req_ena",   144'(req_ena),   144'(0));
        chk("mid_rst_heard_ena", 144'(heard_ena), 144'(0));
        chk("mid_rst_err",       144'(err_cnt),   144'(0));
        nRST = 1'b1;
        tick();
        @(negedge CLK);
        chk("post_rst_say_rdy",   144'(say_rdy),   144'(1));
        chk("post_rst_ind_rdy",   144'(ind_rdy),   144'(1));
        chk("post_rst_req_ena",   144'(req_ena),   144'(0));
        chk("post_rst_heard_ena", 144'(heard_ena), 144'(0));
        repeat (3) tick();
        do_say(32'h00C0FFEE);
        do_ind(mk(8'h00, 8'd1, 32'h00BEEF00), 1'b1);
        repeat (5) tick();

        chk("sb_req_drained",   144'(exp_req.size()),   144'(0));
        chk("sb_heard_drained", 144'(exp_heard.size()), 144'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
